// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, default widths and the divide-by-zero quotient.
package divisor_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_w(DW_DEF);

  localparam logic [DW_DEF-1:0] QUOT_DIV0 = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/divisor_seq_8x4_div_step.sv
// One combinational restoring-division step.
// Shifts in the next dividend bit and keeps the trial difference if it fits.
module div_step
  import divisor_pkg::*;
#(
  parameter int VW = VW_DEF
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW:0]   trial;

  assign shifted = {rem_in, bit_in};
  assign trial   = shifted[VW:0] - {1'b0, divisor};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = q_bit ? trial : shifted[VW:0];

endmodule

// File: rtl/divisor_seq_8x4.sv
// Iterative restoring divider, DW iterations per result, start/done handshake.
// Optional DIVISOR_SELFCHECK_EN adds chk_err: q*d+r is compared with the dividend.
module divisor_seq_8x4
  import divisor_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
`ifdef DIVISOR_SELFCHECK_EN
  ,
  output logic          chk_err
`endif
);

  localparam int CW = cnt_w(DW);

  state_t        state, state_nx;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q;
  logic [VW-1:0] dvs;
  logic [VW:0]   rem, rem_nx;
  logic          q_bit;
  logic          div0;
  logic          zero_dvs;

  assign zero_dvs = (dvs == '0);

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem),
    .bit_in  (q[DW-1]),
    .divisor (dvs),
    .rem_out (rem_nx),
    .q_bit   (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and start acceptance.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (zero_dvs || cnt == '0) state_nx = DONE;
      end
      DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = CALC;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef DIVISOR_SELFCHECK_EN
  logic [DW-1:0]    dvd_cap;
  logic             chk_q;
  logic [DW+VW-1:0] recon;
  logic             chk_now;

  assign recon = (DW+VW)'(q) * (DW+VW)'(dvs)
               + (DW+VW)'(rem[VW-1:0]);
  assign chk_now = !zero_dvs && (recon != (DW+VW)'(dvd_cap));

  // Captured dividend and held check result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_cap <= '0;
      chk_q   <= 1'b0;
    end else if (accept) begin
      dvd_cap <= dividend;
      chk_q   <= 1'b0;
    end else if (state == DONE) begin
      chk_q   <= chk_now;
    end
  end

  assign chk_err = (state == DONE) ? chk_now : chk_q;
`endif

  // Datapath: operand capture, per-step shift, divide-by-zero result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      dvs  <= '0;
      rem  <= '0;
      cnt  <= '0;
      div0 <= 1'b0;
    end else if (accept) begin
      q    <= dividend;
      dvs  <= divisor;
      rem  <= '0;
      cnt  <= CW'(DW - 1);
      div0 <= 1'b0;
    end else if (state == CALC) begin
      if (zero_dvs) begin
        q    <= '1;
        rem  <= '0;
        div0 <= 1'b1;
      end else begin
        q    <= {q[DW-2:0], q_bit};
        rem  <= rem_nx;
        cnt  <= cnt - 1'b1;
      end
    end
  end

  assign busy        = (state == CALC);
  assign done        = (state == DONE);
  assign quotient    = q;
  assign remainder   = rem[VW-1:0];
  assign div_by_zero = div0;

endmodule

// File: tb/tb_divisor_seq_8x4.sv
// Randomized self-checking bench for divisor_seq_8x4.
// Expected results come from plain integer / and % in the bench.
module tb_divisor_seq_8x4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
`ifdef DIVISOR_SELFCHECK_EN
  logic       chk_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  divisor_seq_8x4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
`ifdef DIVISOR_SELFCHECK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Waits for done; returns edges waited and busy cycles seen.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = int'(busy);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      chk("busy_done_excl", int'(busy & done), 0);
      if (done) break;
      if (busy) bc++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag,
                              input int a, input int b);
    int eq, er, ez;
    eq = (b == 0) ? 255 : a / b;
    er = (b == 0) ? 0 : a % b;
    ez = (b == 0) ? 1 : 0;
    chk({tag, "_q"}, int'(quotient), eq);
    chk({tag, "_r"}, int'(remainder), er);
    chk({tag, "_dz"}, int'(div_by_zero), ez);
`ifdef DIVISOR_SELFCHECK_EN
    chk({tag, "_chk"}, int'(chk_err), 0);
`endif
  endtask

  // One full operation; operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input int a, input int b,
                        input bit full);
    int n, bc;
    start    = 1'b1;
    dividend = 8'(a);
    divisor  = 4'(b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    wait_done(n, bc);
    chk({tag, "_lat"}, n, (b == 0) ? 1 : 8);
    check_result(tag, a, b);
    if (full) begin
      chk({tag, "_busy"}, bc, (b == 0) ? 1 : 8);
      @(posedge clk);
      #1;
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_idle"}, int'(busy), 0);
      check_result({tag, "_hold"}, a, b);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n, bc, a, b, seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("after_rst", 200, 7, 1'b1);

    run_op("ff_f", 255, 15, 1'b1);
    run_op("d200_7", 200, 7, 1'b1);
    run_op("d1_15", 1, 15, 1'b1);
    run_op("div0", 45, 0, 1'b1);
    run_op("d45_3", 45, 3, 1'b1);

    start    = 1'b1;
    dividend = 8'd45;
    divisor  = 4'd3;
    @(posedge clk);
    #1;
    dividend = 8'd16;
    divisor  = 4'd2;
    wait_done(n, bc);
    chk("b2b_lat1", n, 8);
    check_result("b2b_1", 45, 3);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'd99;
    divisor  = 4'd5;
    wait_done(n, bc);
    chk("b2b_gap", n + 1, 9);
    check_result("b2b_2", 16, 2);
    @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(255, 0));
      b = (i % 8 == 0) ? 0 : int'($urandom_range(15, 0));
      run_op("rand", a, b, 1'b0);
    end

    for (int x = 1; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        run_op("round", x * y, y, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/divisor_seq_8x4.md
Name: divisor_seq_8x4

Overview:
- Iterative restoring divider: the inverse of the 4x4 combinational multiplier.
- Takes an 8-bit dividend (e.g. a product from uo_out) and a 4-bit divisor.
- Returns an 8-bit quotient and a 4-bit remainder after a fixed multi-cycle computation.
- Sits beside the multiplier in the TinyTapeout tile, using a start/done handshake for round-trip checks (a*b)/b == a.

Parameters:
- DW, 8, dividend and quotient width; also the number of iterations.
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse or level; sampled only when the block can accept.
- dividend  input  DW  captured on the accepting edge.
- divisor  input  VW  captured on the accepting edge.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse when the result becomes valid.
- quotient  output  DW  result; held stable until the next accepted start.
- remainder  output  VW  result; held stable until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor == 0; held with the results.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal registers cleared.
- States: IDLE, CALC, DONE.
- Accepting a start:
  - start=1 in IDLE or DONE captures dividend/divisor at that edge (E0).
  - Iteration counter is loaded with DW-1; partial remainder (VW+1 bits) cleared.
- start while in CALC is ignored; no queueing.
- CALC, once per edge E1..E(DW):
  - shift {rem, dividend MSB} left;
  - trial subtract the zero-extended divisor;
  - if the result is non-negative, keep it and set quotient bit = 1, else restore and set bit = 0.
- Quotient bits are produced MSB first.
- After edge E(DW) the state is DONE:
  - done=1 for exactly that one cycle;
  - quotient/remainder valid from that cycle.
- Latency: start edge to done-high is DW edges (8), so done is visible in cycle 9 counting the start cycle as 1.
- DONE returns to IDLE on the next edge unless start=1, in which case it goes straight to CALC. This gives back-to-back throughput of one result per DW+1 cycles.
- busy=1 in CALC only; busy and done are never high together.
- Divide by zero (captured divisor==0):
  - CALC is skipped; DONE is entered at E1;
  - quotient = all ones (8'hFF), remainder = 0, div_by_zero = 1.
- div_by_zero clears on the next accepted start.
- dividend < divisor: quotient=0, remainder=dividend[VW-1:0].
- Arithmetic is unsigned; no overflow is possible (the maximum quotient 255 fits in DW).
- Input changes after the accepting edge have no effect on the running operation.
- rst asserted mid-CALC aborts immediately to reset values; no done is produced.

Optional Feature:
- Macro DIVISOR_SELFCHECK_EN.
- Defined:
  - adds output port chk_err (1 bit, reset 0);
  - in DONE, for a non-zero divisor, computes quotient*divisor + remainder and compares it with the captured dividend;
  - chk_err=1 alongside done on mismatch, otherwise 0;
  - chk_err is held with the results and forced 0 on a divide by zero.
- Undefined: no port, no multiplier logic; the rest of the behaviour is identical.

Decomposition:
- Package divisor_pkg:
  - state enum (IDLE, CALC, DONE);
  - DW/VW defaults;
  - counter width localparam ($clog2(DW));
  - constant QUOT_DIV0 = all ones.
- Sub-module div_step:
  - combinational single restoring step;
  - inputs: partial remainder, next dividend bit, divisor;
  - outputs: new remainder and quotient bit.
- Top holds the FSM, counter and registers.

Test Plan:
- Reset mid-operation:
  - start dividend=200, divisor=7, assert rst at cycle 4;
  - all outputs must read 0 and no done pulse occurs;
  - after release, a fresh start completes normally.
- Basic division: start with dividend=8'hFF, divisor=4'hF -> done exactly 8 edges later, quotient=17, remainder=0, div_by_zero=0; busy high for 8 cycles.
- Remainder and small dividend: dividend=200, divisor=7 -> quotient=28, remainder=4; dividend=1, divisor=15 -> quotient=0, remainder=1.
- Divide by zero: dividend=45, divisor=0 -> done at E1, quotient=8'hFF, remainder=0, div_by_zero=1; next start with 45/3 -> quotient=15, div_by_zero=0.
- Back-to-back and ignored start:
  - hold start=1 continuously with 45/3 then 16/2 -> done pulses 9 cycles apart with results 15 then 8;
  - operand changes during CALC do not alter the result.
- Round trip with DIVISOR_SELFCHECK_EN: for all a,b in 1..15, divide a*b by b -> quotient=a, remainder=0, chk_err=0 on every done.
